timer_irq_unit: RTL
===================

// Module: timer_irq_unit
// PURPOSE
//  Memory-mapped interval timer that drives the CPU IRQ input consumed by the control decoder.
//  The counter reloads from a period register on overflow and latches an interrupt status bit.
//  IRQ is raised while status and enable are set and the CPU is not in kernel mode.
//  Sits on the data-memory bus beside data RAM; the CPU clears status by a store to TCON.
// PARAMETERS
//  BASE      32'h4000_0000  byte address of TH; TL at BASE+4, TCON at BASE+8
//  PRESCALE  1              clk cycles per counter tick (>=1); 1 = tick every cycle
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  addr         in   32  byte address from ALU result
//  wdata        in   32  store data
//  MemWr        in   1   store strobe, sampled on clk rising edge
//  MemRd        in   1   load strobe
//  rdata        out  32  load data (combinational)
//  kernel_mode  in   1   PC[31]; 1 masks IRQ
//  IRQ          out  1   interrupt request to control decoder
// BEHAVIOUR
//  Registers: TH[31:0] reload value; TL[31:0] counter; TCON[2:0] = {status, irq_en, run}.
//  Reset (reset=0, async): TH=0, TL=0, TCON=0, prescaler=0 -> IRQ=0, rdata=0 immediately.
//  Decode: hit = addr in {BASE, BASE+4, BASE+8} with addr[1:0]==0. Any other addr: no effect.
//  Read: rdata = MemRd&&hit ? register (TCON zero-extended) : 32'h0. Zero latency.
//  Write: on edge with MemWr&&hit, target register <= wdata (TCON <= wdata[2:0]; [31:3] dropped).
//  Prescaler: counts 0..PRESCALE-1 while run=1; tick = run && prescaler==PRESCALE-1,
//   then wraps to 0. run=0 -> prescaler cleared to 0, TL held.
//  Tick: TL==32'hFFFF_FFFF -> TL<=TH and status<=1 if irq_en (else unchanged); otherwise TL<=TL+1.
//   Wrap is 32-bit unsigned; no carry out.
//  IRQ = status & irq_en & ~kernel_mode, combinational from registers: high in the cycle
//   following the overflow edge; drops in the same cycle kernel_mode rises.
//  Collisions on the same edge:
//   - store to TL with tick: store wins; no reload, no status set.
//   - store to TH with overflow: reload uses old TH.
//   - store to TCON with overflow status set: run and irq_en from wdata;
//     status = wdata[2] | set (set wins, so no interrupt is lost).
//  Clearing status: store TCON with bit2=0 -> IRQ low next cycle unless a new overflow collides.
//  Clearing irq_en leaves status intact; IRQ reasserts when irq_en is set again.
//  Store of run=0 takes effect at that edge: the tick of that edge is suppressed.
//  MemRd and MemWr together: store performed at the edge, rdata shows the pre-edge value.
//  Reset mid-count or with IRQ high: all state cleared at once; no residual tick.
// TESTING
//  1 Count at PRESCALE=1, TH=FFFF_FFFC, TL=FFFF_FFFE, TCON=3.
//    Two edges -> TL=FFFF_FFFC, TCON reads 7, IRQ=1; next edge -> TL=FFFF_FFFD.
//  2 IRQ high, kernel_mode=1 -> IRQ=0 that cycle. kernel_mode=0 -> IRQ=1. Store TCON=3 -> IRQ=0 next cycle.
//  3 Store TCON=3 on the same edge as an overflow -> TCON reads 7, IRQ stays 1.
//    Store TL=5 on a tick edge -> TL reads 5.
//  4 PRESCALE=4, TL=0, TCON=1: TL=1 after 4 edges, TL=2 after 8.
//    Store TCON=0 -> TL holds for 10 edges. Re-enable -> next increment after 4 edges.
//  5 Assert reset low asynchronously mid-count with IRQ=1 -> IRQ, TH, TL, TCON all 0 before the next edge.
//    Misaligned or unmapped store (addr=BASE+2, BASE+12) -> no register change; rdata=0.

Source files
------------

// File: rtl/timer_irq_unit.sv
// Interval timer on the data bus: TH reload, TL counter, TCON {status,irq_en,run}.
// Ports: clk, reset (async low), addr/wdata/MemWr/MemRd/rdata bus, kernel_mode, IRQ.
module timer_irq_unit #(
  parameter logic [31:0] BASE     = 32'h4000_0000,
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemWr,
  input  logic        MemRd,
  output logic [31:0] rdata,
  input  logic        kernel_mode,
  output logic        IRQ
);

  localparam int unsigned PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [31:0]   r_th;
  logic [31:0]   r_tl;
  logic          r_status;
  logic          r_en;
  logic          r_run;
  logic [PW-1:0] r_pre;

  logic w_aligned;
  logic w_sel_th;
  logic w_sel_tl;
  logic w_sel_con;
  logic w_wr_th;
  logic w_wr_tl;
  logic w_wr_con;
  logic w_stop;
  logic w_pre_end;
  logic w_tick;
  logic w_ovf;
  logic w_set;

  assign w_aligned = (addr[1:0] == 2'b00);
  assign w_sel_th  = w_aligned && (addr == BASE);
  assign w_sel_tl  = w_aligned && (addr == BASE + 32'd4);
  assign w_sel_con = w_aligned && (addr == BASE + 32'd8);

  assign w_wr_th  = MemWr && w_sel_th;
  assign w_wr_tl  = MemWr && w_sel_tl;
  assign w_wr_con = MemWr && w_sel_con;

  // A store clearing run suppresses the tick of its own edge.
  assign w_stop    = w_wr_con && !wdata[0];
  assign w_pre_end = (r_pre == PMAX);
  assign w_tick    = r_run && w_pre_end && !w_stop;

  // A store to TL on the overflow edge wins over the reload.
  assign w_ovf = w_tick && (r_tl == 32'hFFFF_FFFF) && !w_wr_tl;
  assign w_set = w_ovf && r_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre <= '0;
    end else if (!r_run || w_stop || w_pre_end) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th <= '0;
    end else if (w_wr_th) begin
      r_th <= wdata;
    end
  end

  // Reload reads r_th before any same-edge TH store lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tl <= '0;
    end else if (w_wr_tl) begin
      r_tl <= wdata;
    end else if (w_ovf) begin
      r_tl <= r_th;
    end else if (w_tick) begin
      r_tl <= r_tl + 32'd1;
    end
  end

  // Overflow set is OR-ed into a TCON store so no interrupt is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_status <= 1'b0;
      r_en     <= 1'b0;
      r_run    <= 1'b0;
    end else if (w_wr_con) begin
      r_status <= wdata[2] | w_set;
      r_en     <= wdata[1];
      r_run    <= wdata[0];
    end else if (w_set) begin
      r_status <= 1'b1;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (MemRd) begin
      unique case (1'b1)
        w_sel_th:  rdata = r_th;
        w_sel_tl:  rdata = r_tl;
        w_sel_con: rdata = {29'h0, r_status, r_en, r_run};
        default:   rdata = 32'h0;
      endcase
    end
  end

  assign IRQ = r_status & r_en & ~kernel_mode;

endmodule
